// File: rtl/wb_activity_monitor_if.sv
// Wishbone link signal bundles tapped by wb_activity_monitor.
// iWishbone_Ctrl carries the controller-side strobe, direction and data;
// iWishbone_Peri carries the peripheral-side acknowledge. The monitor only
// ever connects through the read-only "mon" modports.
`timescale 1ns/1ps

interface iWishbone_Ctrl #(
    parameter int DW = 32
);
    logic          stb;
    logic          we;
    logic [DW-1:0] dat;

    modport mon (input stb, input we, input dat);
endinterface

interface iWishbone_Peri;
    logic ack;

    modport mon (input ack);
endinterface

// File: rtl/wb_activity_monitor.sv
// wb_activity_monitor: passive Wishbone activity indicator driving a LED bank.
// LED map: [0] read activity, [1] write activity, [2] transaction pending,
// [3] stall error, [pLeds-1:4] wrapping count of completed transfers.
// Optional feature macro: WB_ACTIVITY_MONITOR_STALL_EN enables the stall
// watchdog (wait counter, forced abandon and sticky bit3). Without it a
// transaction stays pending until acked and bit3 reads 0.
`timescale 1ns/1ps

module wb_activity_monitor #(
    parameter int pLeds     = 8,
    parameter int pStretch  = 16,
    parameter int pTimeout  = 255,
    parameter int pLampTest = 32
) (
    input  logic              clk,
    input  logic              rst,
    iWishbone_Ctrl.mon        wb_c,
    iWishbone_Peri.mon        wb_p,
    output logic [pLeds-1:0]  blinkenlights
);

    localparam int CW = pLeds - 4;
    localparam int SW = $clog2(pStretch + 1);
    // +2 keeps the width non-zero when the lamp test is disabled
    localparam int LW = $clog2(pLampTest + 2);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   rd_q, rd_d;
    logic [SW-1:0]   wr_q, wr_d;
    logic [LW-1:0]   lamp_q;
    logic            complete;
    logic            cdir;
    logic            err_bit;
    logic [pLeds-1:0] leds_d;

`ifdef WB_ACTIVITY_MONITOR_STALL_EN
    localparam int TW = $clog2(pTimeout + 1);
    logic [TW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
`else
    localparam int unused_timeout = pTimeout;
`endif

    // Bus data is tapped but carries no activity information of its own.
    logic unused_dat;
    assign unused_dat = ^wb_c.dat;

    // Tracker next state, completion handling, stretcher countdown and LED image.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        rd_d     = (rd_q != '0) ? rd_q - SW'(1) : '0;
        wr_d     = (wr_q != '0) ? wr_q - SW'(1) : '0;
        complete = 1'b0;
        cdir     = dir_q;
`ifdef WB_ACTIVITY_MONITOR_STALL_EN
        wait_d   = wait_q;
        err_d    = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (wb_c.stb) begin
                    dir_d = wb_c.we;
                    if (wb_p.ack) begin
                        // zero-wait transfer: completes without entering BUSY
                        complete = 1'b1;
                        cdir     = wb_c.we;
                    end else begin
                        state_d = BUSY;
`ifdef WB_ACTIVITY_MONITOR_STALL_EN
                        wait_d  = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (wb_p.ack) begin
                    // ack takes priority over a coinciding timeout
                    complete = 1'b1;
                    state_d  = IDLE;
                end else begin
`ifdef WB_ACTIVITY_MONITOR_STALL_EN
                    wait_d = wait_q + TW'(1);
                    if (wait_q == TW'(pTimeout - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            cnt_d = cnt_q + CW'(1);
            if (cdir) wr_d = SW'(pStretch);
            else      rd_d = SW'(pStretch);
        end

`ifdef WB_ACTIVITY_MONITOR_STALL_EN
        err_bit = err_d;
`else
        err_bit = 1'b0;
`endif
        leds_d = {cnt_d, err_bit, (state_d == BUSY), (wr_d != '0), (rd_d != '0)};
    end

    // Tracker, counter and stretcher state; everything clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
`ifdef WB_ACTIVITY_MONITOR_STALL_EN
            wait_q  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef WB_ACTIVITY_MONITOR_STALL_EN
            wait_q  <= wait_d;
            err_q   <= err_d;
`endif
        end
    end

    // Lamp-test window and registered LED drive; only the output is masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            lamp_q        <= LW'(pLampTest);
            blinkenlights <= '1;
        end else begin
            if (lamp_q != '0) lamp_q <= lamp_q - LW'(1);
            blinkenlights <= (lamp_q != '0) ? '1 : leds_d;
        end
    end

endmodule

// File: tb/tb_wb_activity_monitor.sv
// Directed bench for wb_activity_monitor with default parameters
// (8 LEDs, 16-cycle stretch, 255-cycle timeout, 32-cycle lamp test).
`timescale 1ns/1ps

module tb_wb_activity_monitor;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] blinkenlights;
    int         checks   = 0;
    int         failures = 0;

    iWishbone_Ctrl wb_c_if ();
    iWishbone_Peri wb_p_if ();

    wb_activity_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .wb_c          (wb_c_if),
        .wb_p          (wb_p_if),
        .blinkenlights (blinkenlights)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        checks++;
        assert (blinkenlights === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, blinkenlights, exp);
        end
    endtask

    task automatic hold(input int n, input logic [7:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, exp);
        end
    endtask

    task automatic lamp_release();
        rst = 1'b0;
        hold(32, 8'hFF, "lamp_window");
        hold(1, 8'h00, "lamp_end");
    endtask

    initial begin
        rst = 1'b1;
        wb_c_if.stb = 1'b0;
        wb_c_if.we  = 1'b0;
        wb_c_if.dat = 32'h0;
        wb_p_if.ack = 1'b0;

        // Reset held three cycles, then 32-cycle lamp test
        hold(3, 8'hFF, "reset_ones");
        lamp_release();

        // Read with two-cycle wait
        wb_c_if.stb = 1'b1; wb_c_if.we = 1'b0; wb_c_if.dat = 32'hA5A5_0001;
        tick(); chk("rd_pending0", 8'h04);
        wb_c_if.stb = 1'b0;
        tick(); chk("rd_pending1", 8'h04);
        wb_p_if.ack = 1'b1;
        tick(); chk("rd_ack", 8'h11);
        wb_p_if.ack = 1'b0;
        hold(15, 8'h11, "rd_stretch");
        hold(1, 8'h10, "rd_stretch_end");

        // Write with two-cycle wait
        wb_c_if.stb = 1'b1; wb_c_if.we = 1'b1;
        tick(); chk("wr_pending0", 8'h14);
        wb_c_if.stb = 1'b0;
        tick(); chk("wr_pending1", 8'h14);
        wb_p_if.ack = 1'b1;
        tick(); chk("wr_ack", 8'h22);
        wb_p_if.ack = 1'b0; wb_c_if.we = 1'b0;
        hold(15, 8'h22, "wr_stretch");
        hold(1, 8'h20, "wr_stretch_end");

        // Zero-wait read, retriggered 10 cycles later
        wb_c_if.stb = 1'b1; wb_p_if.ack = 1'b1;
        tick(); chk("zw_first", 8'h31);
        wb_c_if.stb = 1'b0; wb_p_if.ack = 1'b0;
        hold(9, 8'h31, "zw_gap");
        wb_c_if.stb = 1'b1; wb_p_if.ack = 1'b1;
        tick(); chk("zw_second", 8'h41);
        wb_c_if.stb = 1'b0; wb_p_if.ack = 1'b0;
        hold(15, 8'h41, "zw_stretch");
        hold(1, 8'h40, "zw_stretch_end");

        // Back-to-back zero-wait reads through the counter wrap 15 -> 0
        for (int i = 1; i <= 12; i++) begin
            logic [3:0] c;
            c = 4'(4 + i);
            wb_c_if.stb = 1'b1; wb_p_if.ack = 1'b1;
            tick(); chk("wrap_count", {c, 4'h1});
        end
        wb_c_if.stb = 1'b0; wb_p_if.ack = 1'b0;
        hold(15, 8'h01, "wrap_stretch");
        hold(1, 8'h00, "wrap_stretch_end");

        // Spurious ack while idle
        wb_p_if.ack = 1'b1;
        tick(); chk("spurious_ack", 8'h00);
        wb_p_if.ack = 1'b0;
        tick(); chk("spurious_after", 8'h00);

`ifdef WB_ACTIVITY_MONITOR_STALL_EN
        // Stall: error and pending-low exactly 255 cycles after stb
        wb_c_if.stb = 1'b1;
        tick(); chk("stall_pending", 8'h04);
        wb_c_if.stb = 1'b0;
        hold(254, 8'h04, "stall_wait");
        tick(); chk("stall_error", 8'h08);
        wb_p_if.ack = 1'b1;
        tick(); chk("stall_late_ack", 8'h08);
        wb_p_if.ack = 1'b0;
        hold(3, 8'h08, "stall_sticky");
        rst = 1'b1;
        tick(); chk("stall_reset", 8'hFF);
        lamp_release();

        // Ack coinciding with the timeout cycle wins
        wb_c_if.stb = 1'b1;
        tick(); chk("race_pending", 8'h04);
        wb_c_if.stb = 1'b0;
        hold(254, 8'h04, "race_wait");
        wb_p_if.ack = 1'b1;
        tick(); chk("race_ack", 8'h11);
        wb_p_if.ack = 1'b0;
        hold(15, 8'h11, "race_stretch");
        hold(1, 8'h10, "race_end");
`else
        // No watchdog: a long wait stays pending and still completes
        wb_c_if.stb = 1'b1;
        tick(); chk("long_pending", 8'h04);
        wb_c_if.stb = 1'b0;
        hold(300, 8'h04, "long_wait");
        wb_p_if.ack = 1'b1;
        tick(); chk("long_ack", 8'h11);
        wb_p_if.ack = 1'b0;
        hold(15, 8'h11, "long_stretch");
        hold(1, 8'h10, "long_end");
`endif

        // Reset mid-transaction aborts silently
        wb_c_if.stb = 1'b1;
        tick(); chk("abort_pending", 8'h14);
        wb_c_if.stb = 1'b0;
        rst = 1'b1;
        tick(); chk("abort_reset", 8'hFF);
        lamp_release();
        wb_p_if.ack = 1'b1;
        tick(); chk("abort_late_ack", 8'h00);
        wb_p_if.ack = 1'b0;

        // Tracking keeps running under the lamp-test mask
        rst = 1'b1;
        tick(); chk("mask_reset", 8'hFF);
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            wb_c_if.stb = (k == 5);
            wb_p_if.ack = (k == 5);
            tick(); chk("mask_window", 8'hFF);
        end
        wb_c_if.stb = 1'b0; wb_p_if.ack = 1'b0;
        tick(); chk("mask_end", 8'h10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
